// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Definitions shared by the 1:2 bit demux and the lane deserializer that
// sits behind it.
//   NUM_LANES  : number of demux output lanes
//   lane_idx_t : type wide enough to hold a lane select
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_LANES = 2;

    typedef logic [$clog2(NUM_LANES)-1:0] lane_idx_t;

endpackage : demux_pkg

// File: rtl/lane_packer.sv
// ---------------------------------------------------------------------------
// lane_packer
// Serial-to-parallel packer for a single demux lane: shift register, bit
// counter, one-word holding register with valid/ready handshake and a sticky
// overflow flag for words that had nowhere to go.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   cap_en     : capture cap_bit this cycle
//   cap_bit    : serial data bit for this lane
//   ready      : downstream consumer accepts the held word
//   clr_ovf    : synchronous clear of the overflow flag
//   word       : assembled word, stable while word_valid=1
//   word_valid : holding register contains a word
//   ovf        : sticky, a completed word was dropped
// ---------------------------------------------------------------------------
module lane_packer
    import demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             cap_bit,
    input  logic             ready,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             ovf
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_ovf;

    logic [WIDTH-1:0] w_assembled;
    logic             w_complete;
    logic             w_free;
    logic             w_load;

    // Shift contents with the current bit appended; on the final bit of a
    // word this is the complete word.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_assembled = {r_shift[WIDTH-2:0], cap_bit};
        end else begin : g_lsb_first
            assign w_assembled = {cap_bit, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_complete = cap_en && (r_cnt == CNT_LAST);
    // A word being drained on this edge frees the slot for a word loading
    // on the same edge.
    assign w_free     = !r_valid || ready;
    assign w_load     = w_complete && w_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (cap_en) begin
                if (w_complete) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= w_assembled;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end

            if (w_load) begin
                r_word  <= w_assembled;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            // Setting takes priority over a coincident clear.
            if (w_complete && !w_free) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign word       = r_word;
    assign word_valid = r_valid;
    assign ovf        = r_ovf;

endmodule : lane_packer

// File: rtl/lane_deserializer.sv
// ---------------------------------------------------------------------------
// lane_deserializer
// Takes the two outputs of the 1:2 bit demux plus its select and packs each
// lane's serial stream into WIDTH-bit words, one lane_packer per lane.
// Ports:
//   clk, rst           : clock / asynchronous active-high reset
//   bit_valid          : qualifies sel/y0/y1
//   sel                : demux select, 0 = lane 0, 1 = lane 1
//   y0, y1             : demux lane outputs
//   word0/1            : assembled words
//   word0/1_valid      : word available
//   word0/1_ready      : consumer accepts word
//   ovf0/1             : sticky dropped-word flags
//   clr_ovf            : synchronous clear of both ovf flags
// ---------------------------------------------------------------------------
module lane_deserializer
    import demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             sel,
    input  logic             y0,
    input  logic             y1,
    output logic [WIDTH-1:0] word0,
    output logic             word0_valid,
    input  logic             word0_ready,
    output logic [WIDTH-1:0] word1,
    output logic             word1_valid,
    input  logic             word1_ready,
    output logic             ovf0,
    output logic             ovf1,
    input  logic             clr_ovf
);

    lane_idx_t              w_sel_lane;
    logic [NUM_LANES-1:0]   w_cap_en;
    logic [NUM_LANES-1:0]   w_lane_bit;
    logic [NUM_LANES-1:0]   w_ready;
    logic [NUM_LANES-1:0]   w_valid;
    logic [NUM_LANES-1:0]   w_ovf;
    logic [WIDTH-1:0]       w_word [NUM_LANES];

    assign w_sel_lane = lane_idx_t'(sel);
    assign w_lane_bit = {y1, y0};
    assign w_ready    = {word1_ready, word0_ready};

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            // Only the addressed lane sees a capture; the other lane's demux
            // output is ignored.
            assign w_cap_en[gi] = bit_valid && (w_sel_lane == lane_idx_t'(gi));

            lane_packer #(
                .WIDTH     (WIDTH),
                .MSB_FIRST (MSB_FIRST)
            ) u_packer (
                .clk        (clk),
                .rst        (rst),
                .cap_en     (w_cap_en[gi]),
                .cap_bit    (w_lane_bit[gi]),
                .ready      (w_ready[gi]),
                .clr_ovf    (clr_ovf),
                .word       (w_word[gi]),
                .word_valid (w_valid[gi]),
                .ovf        (w_ovf[gi])
            );
        end
    endgenerate

    assign word0       = w_word[0];
    assign word1       = w_word[1];
    assign word0_valid = w_valid[0];
    assign word1_valid = w_valid[1];
    assign ovf0        = w_ovf[0];
    assign ovf1        = w_ovf[1];

endmodule : lane_deserializer

// File: doc/lane_deserializer.md
Name: lane_deserializer

Overview:
- Consumes the two outputs of the 1:2 bit demux (y0, y1) plus its select, and packs each lane's serial bit stream into WIDTH-bit parallel words.
- Each lane has its own shift register, bit counter and one-word output holding register with a valid/ready handshake.
- Sits directly downstream of the demux. Feeds word-level consumers, one per lane.

Parameters:
- WIDTH, 8, bits per assembled word; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 means the first received bit lands in word[WIDTH-1]; 0 means it lands in word[0].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_valid  input  1  qualifies sel/y0/y1 this cycle.
- sel  input  1  demux select; 0 means lane 0 is addressed, 1 means lane 1.
- y0  input  1  demux lane-0 output.
- y1  input  1  demux lane-1 output.
- word0  output  WIDTH  lane-0 assembled word; stable while word0_valid=1.
- word0_valid  output  1  lane-0 word available.
- word0_ready  input  1  lane-0 consumer accepts the word.
- word1  output  WIDTH  lane-1 assembled word.
- word1_valid  output  1  lane-1 word available.
- word1_ready  input  1  lane-1 consumer accepts the word.
- ovf0  output  1  sticky: a lane-0 word was dropped.
- ovf1  output  1  sticky: a lane-1 word was dropped.
- clr_ovf  input  1  synchronous clear of ovf0 and ovf1.

Behaviour:
- Reset (asynchronous, active-high, effective immediately regardless of clk):
  - Forces all shift registers, counters, word0/word1, word*_valid and ovf* to 0.
  - A partially assembled word is discarded. After reset release, the next accepted bit is bit 1 of a fresh word.
- Lane capture:
  - A lane L captures only when bit_valid=1 and sel=L. The captured bit is y0 for L=0 and y1 for L=1.
  - The non-selected lane input is ignored. With bit_valid=0, no state changes except handshake drain and ovf clear.
- Per-lane counter:
  - Width $clog2(WIDTH), runs 0..WIDTH-1.
  - On each capture: if cnt < WIDTH-1, shift the bit in and increment cnt.
  - If cnt == WIDTH-1 the word is complete: the assembled word is the shifted contents plus the current bit, and cnt wraps to 0.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit enters at position 0.
  - MSB_FIRST=0: shift right, new bit enters at position WIDTH-1.
- Word completion and holding register (per lane):
  - The holding register is free if word_valid=0, or if word_valid=1 and word_ready=1 in the same cycle (drain and load coincide).
  - If free: load word, word_valid=1 on the next cycle. Latency is 1 clock from the edge capturing the final bit to word_valid high.
  - If not free: the completed word is dropped, ovf sets on the next edge, and the held word is unchanged.
- Handshake:
  - Transfer occurs on an edge where valid=1 and ready=1. Valid then deasserts unless a new word loads on that same edge.
  - valid must not deassert without a transfer. word is constant while valid=1.
  - ready may be high while valid=0, with no effect.
- Overflow flags:
  - Sticky until clr_ovf=1, which clears on the next edge.
  - If set and clear occur on the same edge, set wins.
- Lane independence:
  - Lanes never share state. Lane 0 activity never alters lane-1 counters or outputs.
  - Both lanes may present valid words simultaneously.

Decomposition:
- Package demux_pkg:
  - NUM_LANES = 2.
  - typedef logic [$clog2(NUM_LANES)-1:0] lane_idx_t.
  - Shared by the demux and this block.
- Sub-module lane_packer (params WIDTH, MSB_FIRST):
  - Contains shift register, counter, holding register, handshake and ovf.
  - Inputs: cap_en, cap_bit, ready, clr_ovf.
  - Instantiated twice.
- The top level derives cap_en per lane from bit_valid and sel, and routes y0/y1.

Test Plan:
1. Assert rst mid-cycle with no clock edge -> all outputs 0 immediately; word0/word1 = 0, valids and ovf* = 0.
2. sel=0, bit_valid=1, y0 = 1,0,1,1,0,0,1,0 (8 cycles), MSB_FIRST=1, word0_ready=1 -> word0=8'hB2, word0_valid high exactly 1 cycle after the 8th bit, for one cycle; lane 1 stays idle.
3. Alternate sel each cycle, lane 0 carrying 8'hA5 and lane 1 carrying 8'h3C, with random bit_valid gaps -> word0=8'hA5 and word1=8'h3C; gaps do not advance counters.
4. word0_ready=0, send two lane-0 words (8'h11 then 8'h22) -> word0 holds 8'h11 and ovf0=1. Then raise word0_ready -> one transfer of 8'h11. Then pulse clr_ovf -> ovf0=0.
5. word0_valid=1 holding 8'h11 and word0_ready=1 on the same edge the 8th bit of 8'h22 arrives -> no overflow; word0=8'h22 next cycle, valid stays high.
6. Assert rst after 4 lane-1 bits, release, then send 8 bits of 8'hC3 -> word1=8'hC3 with no contamination from the partial word. Repeat test 2 with MSB_FIRST=0 -> word0=8'h4D.
